// File: rtl/cache_fill_fsm_pkg.sv
// Shared constants and types for the L1 miss-fill controller and its cache arrays.
// Widths follow from the block geometry: WORDS 16-bit words per block.
package cache_fill_fsm_pkg;

  localparam int WORDS             = 8;
  localparam int MEM_LAT           = 4;
  localparam int BLOCK_OFFSET_BITS = $clog2(2 * WORDS);
  localparam int WORD_IDX_BITS     = $clog2(WORDS);
  localparam int REQ_CNT_BITS      = WORD_IDX_BITS + 1;
  localparam int ADDR_BITS         = 16;
  localparam int TAG_BITS          = ADDR_BITS - BLOCK_OFFSET_BITS;

  typedef enum logic {
    FSM_IDLE = 1'b0,
    FSM_FILL = 1'b1
  } fill_state_e;

  // Upper address bits that identify the block; the in-block offset is dropped.
  function automatic logic [TAG_BITS-1:0] block_tag(input logic [ADDR_BITS-1:0] addr);
    return addr[ADDR_BITS-1:BLOCK_OFFSET_BITS];
  endfunction

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Signal bundle between the fill controller (master) and the cache/memory side (slave).
// There is no back-pressure: memory_en is a fire-and-forget request, and every
// memory_data_valid cycle carries exactly one word that must be consumed that cycle.
interface cache_fill_fsm_if;
  import cache_fill_fsm_pkg::*;

  logic                     miss_detected;
  logic [ADDR_BITS-1:0]     miss_address;
  logic                     memory_data_valid;
  logic                     fsm_busy;
  logic                     memory_en;
  logic [ADDR_BITS-1:0]     memory_address;
  logic                     write_data_array;
  logic [WORD_IDX_BITS-1:0] fill_word;
  logic                     write_tag_array;
  fill_state_e              state;

  modport master (
    input  miss_detected, miss_address, memory_data_valid,
    output fsm_busy, memory_en, memory_address, write_data_array, fill_word,
           write_tag_array, state
  );

  modport slave (
    output miss_detected, miss_address, memory_data_valid,
    input  fsm_busy, memory_en, memory_address, write_data_array, fill_word,
           write_tag_array, state
  );

endinterface

// File: rtl/cache_fill_fsm_fill_counter.sv
// Width-parameterised up-counter with synchronous clear (priority over enable).
module fill_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// Miss-fill controller: streams one block of words from pipelined memory into
// the data array, then pulses the tag write on the last word.
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  cache_fill_fsm_if.master bus
);

  fill_state_e              state_q;
  fill_state_e              state_d;
  logic [TAG_BITS-1:0]      base_q;
  logic                     base_load;
  logic [REQ_CNT_BITS-1:0]  req_cnt;
  logic [WORD_IDX_BITS-1:0] rcv_cnt;
  logic                     cnt_clear;
  logic                     req_en;
  logic                     rcv_en;
  logic                     unused_offset;

  // Offset bits of the miss address are irrelevant: fills always start at word 0.
  assign unused_offset = ^bus.miss_address[BLOCK_OFFSET_BITS-1:0];

  fill_counter #(.W(REQ_CNT_BITS)) u_req_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clear),
    .en    (req_en),
    .count (req_cnt)
  );

  fill_counter #(.W(WORD_IDX_BITS)) u_rcv_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clear),
    .en    (rcv_en),
    .count (rcv_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FSM_IDLE;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      if (base_load) begin
        base_q <= block_tag(bus.miss_address);
      end
    end
  end

  always_comb begin
    state_d              = state_q;
    base_load            = 1'b0;
    cnt_clear            = 1'b0;
    bus.fsm_busy         = 1'b0;
    bus.memory_en        = 1'b0;
    bus.memory_address   = '0;
    bus.write_data_array = 1'b0;
    bus.fill_word        = '0;
    bus.write_tag_array  = 1'b0;

    case (state_q)
      FSM_IDLE: begin
        if (bus.miss_detected) begin
          state_d   = FSM_FILL;
          base_load = 1'b1;
          cnt_clear = 1'b1;
        end
      end
      FSM_FILL: begin
        bus.fsm_busy = 1'b1;
        if (req_cnt < REQ_CNT_BITS'(WORDS)) begin
          bus.memory_en      = 1'b1;
          // Concatenation, not addition: the word offset can never carry into the tag.
          bus.memory_address = {base_q, req_cnt[WORD_IDX_BITS-1:0], 1'b0};
        end
        if (bus.memory_data_valid) begin
          bus.write_data_array = 1'b1;
          bus.fill_word        = rcv_cnt;
          if (rcv_cnt == WORD_IDX_BITS'(WORDS - 1)) begin
            bus.write_tag_array = 1'b1;
            state_d             = FSM_IDLE;
          end
        end
      end
      default: state_d = FSM_IDLE;
    endcase
  end

  assign req_en    = bus.memory_en;
  assign rcv_en    = bus.write_data_array;
  assign bus.state = state_q;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with a fixed-latency pipelined memory model.
module tb_cache_fill_fsm;
  import cache_fill_fsm_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [MEM_LAT-1:0] pipe;

  cache_fill_fsm_if bus ();

  cache_fill_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare every output on the falling edge, away from the active edge.
  task automatic chk(input string tg, input logic e_busy, input logic e_en,
                     input logic [15:0] e_addr, input logic e_wr,
                     input logic [WORD_IDX_BITS-1:0] e_fw, input logic e_tag);
    @(negedge clk);
    total++;
    assert (bus.fsm_busy === e_busy && bus.memory_en === e_en &&
            bus.memory_address === e_addr && bus.write_data_array === e_wr &&
            bus.fill_word === e_fw && bus.write_tag_array === e_tag &&
            bus.state === (e_busy ? FSM_FILL : FSM_IDLE))
    else begin
      bad++;
      $error("FAIL %s: got busy=%b en=%b addr=%h wr=%b fw=%0d tag=%b, want busy=%b en=%b addr=%h wr=%b fw=%0d tag=%b",
             tg, bus.fsm_busy, bus.memory_en, bus.memory_address, bus.write_data_array,
             bus.fill_word, bus.write_tag_array, e_busy, e_en, e_addr, e_wr, e_fw, e_tag);
    end
  endtask

  task automatic chk_idle(input string tg);
    chk(tg, 1'b0, 1'b0, 16'h0000, 1'b0, '0, 1'b0);
  endtask

  // Advance one cycle; the memory model returns each request MEM_LAT cycles later.
  task automatic adv();
    logic en_s;
    en_s = bus.memory_en;
    @(posedge clk);
    #1;
    pipe = {pipe[MEM_LAT-2:0], en_s};
    bus.memory_data_valid = pipe[MEM_LAT-1];
  endtask

  // Present a miss in cycle 0 and check cycles 1..ncyc against the expected fill timeline.
  task automatic do_fill(input logic [15:0] ma, input logic hold, input int ncyc,
                         input string tg);
    logic [15:0] base;
    logic e_en, e_wr, e_tag;
    logic [15:0] e_addr;
    logic [WORD_IDX_BITS-1:0] e_fw;
    base = {ma[15:4], 4'h0};
    bus.miss_detected = 1'b1;
    bus.miss_address  = ma;
    chk_idle({tg, "_c0"});
    adv();
    if (!hold) bus.miss_detected = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      e_en   = (c <= WORDS);
      e_addr = e_en ? base + 16'(2 * (c - 1)) : 16'h0000;
      e_wr   = (c >= 1 + MEM_LAT) && (c <= WORDS + MEM_LAT);
      e_fw   = e_wr ? WORD_IDX_BITS'(c - 1 - MEM_LAT) : '0;
      e_tag  = (c == WORDS + MEM_LAT);
      chk($sformatf("%s_c%0d", tg, c), 1'b1, e_en, e_addr, e_wr, e_fw, e_tag);
      adv();
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    pipe  = '0;
    rst_n = 1'b0;
    bus.miss_detected     = 1'b0;
    bus.miss_address      = 16'h0000;
    bus.memory_data_valid = 1'b0;

    // 1: reset held for two cycles, then idle
    chk_idle("rst_0"); adv();
    chk_idle("rst_1"); adv();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk_idle($sformatf("idle_%0d", i));
      adv();
    end

    // 2: single fill, then busy drops in cycle 13
    do_fill(16'h1236, 1'b0, 12, "fill1236");
    chk_idle("fill1236_c13");
    adv();

    // 3: top of memory, no wrap
    do_fill(16'hFFFF, 1'b0, 12, "fillFFFF");
    chk_idle("fillFFFF_c13");
    adv();

    // 4a: spurious memory_data_valid in IDLE
    bus.memory_data_valid = 1'b1;
    chk_idle("spur_valid");
    adv();
    chk_idle("spur_after");
    adv();

    // 4b: miss held through a whole fill -> one fill, IDLE cycle, second fill
    do_fill(16'h3456, 1'b1, 12, "hold1");
    do_fill(16'h3456, 1'b0, 12, "hold2");
    chk_idle("hold_end");
    adv();

    // 5: asynchronous reset after the third data word
    do_fill(16'h0500, 1'b0, 7, "abort");
    rst_n = 1'b0;
    #1;
    total++;
    assert (bus.fsm_busy === 1'b0 && bus.memory_en === 1'b0 &&
            bus.memory_address === 16'h0000 && bus.write_data_array === 1'b0 &&
            bus.write_tag_array === 1'b0)
    else begin
      bad++;
      $error("FAIL abort_async: got busy=%b en=%b addr=%h wr=%b tag=%b, want all 0",
             bus.fsm_busy, bus.memory_en, bus.memory_address, bus.write_data_array,
             bus.write_tag_array);
    end
    chk_idle("abort_rst0"); adv();
    chk_idle("abort_rst1"); adv();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_idle($sformatf("abort_drain%0d", i));
      adv();
    end
    do_fill(16'h0040, 1'b0, 12, "fill0040");
    chk_idle("fill0040_c13");
    adv();

    // 6: back-to-back misses, second one in the cycle after the tag pulse
    do_fill(16'h1000, 1'b0, 12, "b2b1000");
    do_fill(16'h2000, 1'b0, 12, "b2b2000");
    chk_idle("b2b_end");
    adv();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
